// File: rtl/pur_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pur_reset_sequencer
//  Purpose  : Power-up reset controller behind the device PUR net. It
//             synchronizes PUR release, stretches it, then releases the
//             downstream reset domains one at a time. Each release waits for
//             that domain's ready/lock acknowledge. Soft restart is supported,
//             and a missing acknowledge raises a sticky fault flag.
//  Revision : 1.0  initial release
// ============================================================================
module pur_reset_sequencer #(
    parameter int                    NUM_STAGES  = 3,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    RST_PULSE   = 16,
    parameter int                    GAP_CYCLES  = 4,
    parameter int                    ACK_TIMEOUT = 255,
    parameter logic [NUM_STAGES-1:0] ACK_MASK    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_pur_n,
    input  logic                  i_soft_req,
    input  logic [NUM_STAGES-1:0] i_ack,
    output logic [NUM_STAGES-1:0] o_rstn,
    output logic [3:0]            o_stage,
    output logic                  o_ready,
    output logic                  o_fault
);

    // One shared counter serves the stretch, gap and timeout phases.
    // It is sized for the largest of the three terminal counts.
    localparam int c_max_a = (RST_PULSE > GAP_CYCLES) ? RST_PULSE : GAP_CYCLES;
    localparam int c_max   = (c_max_a > ACK_TIMEOUT) ? c_max_a : ACK_TIMEOUT;
    localparam int c_cnt_w = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(RST_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = (GAP_CYCLES > 0) ? c_cnt_w'(GAP_CYCLES - 1) : '0;
    localparam logic [c_cnt_w-1:0] c_to_last    = c_cnt_w'(ACK_TIMEOUT - 1);
    localparam logic [3:0]         c_stage_last = 4'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_STRETCH  = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [3:0]             r_stage;
    logic [NUM_STAGES-1:0]  r_rstn;
    logic                   r_ready;
    logic                   r_fault;

    state_t                 w_state_next;
    logic [c_cnt_w-1:0]     w_cnt_next;
    logic [3:0]             w_stage_next;
    logic [NUM_STAGES-1:0]  w_rstn_next;
    logic                   w_ready_next;
    logic                   w_fault_next;

    logic [NUM_STAGES-1:0]  w_ack_eff;
    logic                   w_ack_cur;
    logic [NUM_STAGES-1:0]  w_rstn_upto;

    assign w_ack_eff = i_ack | ACK_MASK;

    // Select the effective ack of the current stage and build the release
    // pattern: every stage up to and including r_stage is out of reset.
    always_comb begin
        w_ack_cur   = 1'b0;
        w_rstn_upto = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (4'(i) == r_stage) begin
                w_ack_cur = w_ack_eff[i];
            end
            w_rstn_upto[i] = (4'(i) <= r_stage);
        end
    end

    // PUR release synchronizer: ones shift in once PUR is deasserted.
    always_ff @(posedge i_clk or negedge i_pur_n) begin
        if (!i_pur_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_pur_n) begin
        if (!i_pur_n) begin
            r_state <= ST_SYNC;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rstn  <= '0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_stage <= w_stage_next;
            r_rstn  <= w_rstn_next;
            r_ready <= w_ready_next;
            r_fault <= w_fault_next;
        end
    end

    // Next-state and next-output logic; soft restart overrides everything
    // except the synchronizer phase.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stage_next = r_stage;
        w_rstn_next  = r_rstn;
        w_ready_next = r_ready;
        w_fault_next = r_fault;

        if (i_soft_req && (r_state != ST_SYNC)) begin
            w_state_next = ST_STRETCH;
            w_cnt_next   = '0;
            w_stage_next = '0;
            w_rstn_next  = '0;
            w_ready_next = 1'b0;
            w_fault_next = 1'b0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    // The cycle spent noticing the last synchronizer flop
                    // counts as the first stretch cycle.
                    if (r_sync[SYNC_STAGES-1]) begin
                        if (RST_PULSE == 1) begin
                            w_state_next = ST_RELEASE;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = ST_STRETCH;
                            w_cnt_next   = c_cnt_w'(1);
                        end
                    end
                end

                ST_STRETCH: begin
                    if (r_cnt == c_pulse_last) begin
                        w_state_next = ST_RELEASE;
                        w_cnt_next   = '0;
                        w_stage_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_w'(1);
                    end
                end

                ST_RELEASE: begin
                    w_rstn_next  = w_rstn_upto;
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    if (w_ack_cur) begin
                        w_cnt_next = '0;
                        if (r_stage == c_stage_last) begin
                            w_state_next = ST_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            w_state_next = ST_RELEASE;
                            w_stage_next = r_stage + 4'd1;
                        end else begin
                            w_state_next = ST_GAP;
                        end
                    end else if (r_cnt == c_to_last) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_w'(1);
                    end
                end

                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        w_state_next = ST_RELEASE;
                        w_cnt_next   = '0;
                        w_stage_next = r_stage + 4'd1;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_w'(1);
                    end
                end

                ST_DONE: begin
                    // Any unmasked ack dropping is a lock loss, so the whole
                    // sequence is stretched and replayed.
                    if (!(&w_ack_eff)) begin
                        w_state_next = ST_STRETCH;
                        w_cnt_next   = '0;
                        w_stage_next = '0;
                        w_rstn_next  = '0;
                        w_ready_next = 1'b0;
                    end else begin
                        w_ready_next = 1'b1;
                    end
                end

                ST_FAULT: begin
                    w_rstn_next  = '0;
                    w_ready_next = 1'b0;
                    w_fault_next = 1'b1;
                end

                default: begin
                    w_state_next = ST_SYNC;
                    w_cnt_next   = '0;
                    w_stage_next = '0;
                    w_rstn_next  = '0;
                    w_ready_next = 1'b0;
                    w_fault_next = 1'b0;
                end
            endcase
        end
    end

    assign o_rstn  = r_rstn;
    assign o_stage = r_stage;
    assign o_ready = r_ready;
    assign o_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pur_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pur_reset_sequencer
//  Purpose  : Scoreboard bench for pur_reset_sequencer. Three instances:
//             defaults, a short ack timeout, and ACK[0] masked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pur_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: defaults
    logic       pur_a = 1'b0, soft_a = 1'b0;
    logic [2:0] ack_a = 3'b111;
    logic [2:0] rstn_a; logic [3:0] stage_a; logic ready_a, fault_a;
    // instance 1: ACK_TIMEOUT = 8
    logic       pur_t = 1'b0, soft_t = 1'b0;
    logic [2:0] ack_t = 3'b000;
    logic [2:0] rstn_t; logic [3:0] stage_t; logic ready_t, fault_t;
    // instance 2: ACK_MASK = 3'b001
    logic       pur_m = 1'b0, soft_m = 1'b0;
    logic [2:0] ack_m = 3'b111;
    logic [2:0] rstn_m; logic [3:0] stage_m; logic ready_m, fault_m;

    pur_reset_sequencer dut (
        .i_clk(clk), .i_pur_n(pur_a), .i_soft_req(soft_a), .i_ack(ack_a),
        .o_rstn(rstn_a), .o_stage(stage_a), .o_ready(ready_a), .o_fault(fault_a));

    pur_reset_sequencer #(.ACK_TIMEOUT(8)) dut_to (
        .i_clk(clk), .i_pur_n(pur_t), .i_soft_req(soft_t), .i_ack(ack_t),
        .o_rstn(rstn_t), .o_stage(stage_t), .o_ready(ready_t), .o_fault(fault_t));

    pur_reset_sequencer #(.ACK_MASK(3'b001)) dut_mk (
        .i_clk(clk), .i_pur_n(pur_m), .i_soft_req(soft_m), .i_ack(ack_m),
        .o_rstn(rstn_m), .o_stage(stage_m), .o_ready(ready_m), .o_fault(fault_m));

    typedef struct {
        int         cyc;
        int         inst;
        logic [2:0] rstn;
        logic       ready;
        logic       fault;
        logic [3:0] stage;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic expect_at(input int c, input int inst, input logic [2:0] r,
                             input logic rd, input logic f, input logic [3:0] s,
                             input string nm);
        exp_t e;
        e.cyc = c; e.inst = inst; e.rstn = r; e.ready = rd; e.fault = f;
        e.stage = s; e.name = nm;
        sb.push_back(e);
    endtask

    // Returns just after rising edge number c.
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: on each falling edge, compare every expectation due now.
    exp_t       mon_e;
    logic [2:0] a_r;
    logic [3:0] a_s;
    logic       a_rd, a_f;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            case (mon_e.inst)
                1:       begin a_r = rstn_t; a_rd = ready_t; a_f = fault_t; a_s = stage_t; end
                2:       begin a_r = rstn_m; a_rd = ready_m; a_f = fault_m; a_s = stage_m; end
                default: begin a_r = rstn_a; a_rd = ready_a; a_f = fault_a; a_s = stage_a; end
            endcase
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for edge %0d checked late at edge %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (a_r !== mon_e.rstn || a_rd !== mon_e.ready ||
                         a_f !== mon_e.fault || a_s !== mon_e.stage) begin
                n_bad++;
                $display("FAIL %s @edge %0d inst %0d: got rstn=%b ready=%b fault=%b stage=%0d, want rstn=%b ready=%b fault=%b stage=%0d",
                         mon_e.name, cyc, mon_e.inst, a_r, a_rd, a_f, a_s,
                         mon_e.rstn, mon_e.ready, mon_e.fault, mon_e.stage);
            end
        end
    end

    initial begin
        int c0, b, d, c1, t0, m0;

        // Power-up with all acks high: releases at +19, +25, +31, READY at +33.
        c0 = 2;
        go_to(c0);
        pur_a = 1'b1;
        expect_at(c0,      0, 3'b000, 1'b0, 1'b0, 4'd0, "por_reset");
        expect_at(c0 + 18, 0, 3'b000, 1'b0, 1'b0, 4'd0, "por_pre_rel0");
        expect_at(c0 + 19, 0, 3'b001, 1'b0, 1'b0, 4'd0, "por_rel0");
        expect_at(c0 + 23, 0, 3'b001, 1'b0, 1'b0, 4'd0, "por_gap0");
        expect_at(c0 + 25, 0, 3'b011, 1'b0, 1'b0, 4'd1, "por_rel1");
        expect_at(c0 + 30, 0, 3'b011, 1'b0, 1'b0, 4'd2, "por_stage2");
        expect_at(c0 + 31, 0, 3'b111, 1'b0, 1'b0, 4'd2, "por_rel2");
        expect_at(c0 + 32, 0, 3'b111, 1'b0, 1'b0, 4'd2, "por_pre_ready");
        expect_at(c0 + 33, 0, 3'b111, 1'b1, 1'b0, 4'd2, "por_ready");

        // Lock loss: one-cycle drop of ACK[0] while DONE.
        go_to(c0 + 40);
        expect_at(c0 + 40, 0, 3'b111, 1'b1, 1'b0, 4'd2, "done_hold");
        ack_a = 3'b110;
        go_to(c0 + 41);
        ack_a = 3'b111;
        expect_at(c0 + 41, 0, 3'b000, 1'b0, 1'b0, 4'd0, "lockloss");
        expect_at(c0 + 57, 0, 3'b000, 1'b0, 1'b0, 4'd0, "ll_pre_rel0");
        expect_at(c0 + 58, 0, 3'b001, 1'b0, 1'b0, 4'd0, "ll_rel0");
        expect_at(c0 + 71, 0, 3'b111, 1'b0, 1'b0, 4'd2, "ll_pre_ready");
        expect_at(c0 + 72, 0, 3'b111, 1'b1, 1'b0, 4'd2, "ll_ready");

        // Soft restart, then ACK[1] raised 40 cycles after RSTN_O[1].
        go_to(c0 + 80);
        soft_a = 1'b1;
        ack_a  = 3'b101;
        go_to(c0 + 81);
        soft_a = 1'b0;
        b = c0 + 81;
        expect_at(b,      0, 3'b000, 1'b0, 1'b0, 4'd0, "soft_restart");
        expect_at(b + 17, 0, 3'b001, 1'b0, 1'b0, 4'd0, "dly_rel0");
        expect_at(b + 23, 0, 3'b011, 1'b0, 1'b0, 4'd1, "dly_rel1");
        go_to(b + 63);
        expect_at(b + 63, 0, 3'b011, 1'b0, 1'b0, 4'd1, "dly_waiting");
        ack_a = 3'b111;
        expect_at(b + 68, 0, 3'b011, 1'b0, 1'b0, 4'd2, "dly_gap_end");
        expect_at(b + 69, 0, 3'b111, 1'b0, 1'b0, 4'd2, "dly_rel2");
        expect_at(b + 70, 0, 3'b111, 1'b0, 1'b0, 4'd2, "dly_pre_ready");
        expect_at(b + 71, 0, 3'b111, 1'b1, 1'b0, 4'd2, "dly_ready");

        // Collision: SOFT_REQ on the same edge ACK[0] is first seen high.
        d = b + 80;
        go_to(d);
        soft_a = 1'b1;
        ack_a  = 3'b000;
        go_to(d + 1);
        soft_a = 1'b0;
        expect_at(d + 1,  0, 3'b000, 1'b0, 1'b0, 4'd0, "col_restart");
        expect_at(d + 18, 0, 3'b001, 1'b0, 1'b0, 4'd0, "col_rel0");
        expect_at(d + 20, 0, 3'b001, 1'b0, 1'b0, 4'd0, "col_waiting");
        go_to(d + 20);
        soft_a = 1'b1;
        ack_a  = 3'b111;
        go_to(d + 21);
        soft_a = 1'b0;
        expect_at(d + 21, 0, 3'b000, 1'b0, 1'b0, 4'd0, "col_soft_wins");
        expect_at(d + 26, 0, 3'b000, 1'b0, 1'b0, 4'd0, "col_no_rel1");
        expect_at(d + 38, 0, 3'b001, 1'b0, 1'b0, 4'd0, "col_rel0_again");
        expect_at(d + 40, 0, 3'b001, 1'b0, 1'b0, 4'd0, "col_in_gap");

        // PUR pulsed low mid-GAP: outputs must clear before the next edge.
        go_to(d + 41);
        expect_at(d + 41, 0, 3'b000, 1'b0, 1'b0, 4'd0, "pur_async");
        pur_a = 1'b0;
        go_to(d + 42);
        pur_a = 1'b1;
        c1 = d + 42;
        expect_at(c1,      0, 3'b000, 1'b0, 1'b0, 4'd0, "repur_reset");
        expect_at(c1 + 18, 0, 3'b000, 1'b0, 1'b0, 4'd0, "repur_pre_rel0");
        expect_at(c1 + 19, 0, 3'b001, 1'b0, 1'b0, 4'd0, "repur_rel0");

        // Timeout instance: ACK[0] never arrives; FAULT 9 edges after release.
        t0 = c1 + 25;
        go_to(t0);
        pur_t = 1'b1;
        expect_at(t0,      1, 3'b000, 1'b0, 1'b0, 4'd0, "to_reset");
        expect_at(t0 + 19, 1, 3'b001, 1'b0, 1'b0, 4'd0, "to_rel0");
        expect_at(t0 + 27, 1, 3'b001, 1'b0, 1'b0, 4'd0, "to_last_wait");
        expect_at(t0 + 28, 1, 3'b000, 1'b0, 1'b1, 4'd0, "to_fault");
        go_to(t0 + 35);
        expect_at(t0 + 35, 1, 3'b000, 1'b0, 1'b1, 4'd0, "to_fault_sticky");
        soft_t = 1'b1;
        go_to(t0 + 36);
        soft_t = 1'b0;
        expect_at(t0 + 36, 1, 3'b000, 1'b0, 1'b0, 4'd0, "to_soft_clear");
        expect_at(t0 + 52, 1, 3'b000, 1'b0, 1'b0, 4'd0, "to_pre_rel0");
        expect_at(t0 + 53, 1, 3'b001, 1'b0, 1'b0, 4'd0, "to_rel0_again");

        // Masked instance: the same ACK[0] drop in DONE has no effect.
        m0 = t0 + 60;
        go_to(m0);
        pur_m = 1'b1;
        expect_at(m0 + 33, 2, 3'b111, 1'b1, 1'b0, 4'd2, "mask_ready");
        go_to(m0 + 40);
        ack_m = 3'b110;
        go_to(m0 + 41);
        ack_m = 3'b111;
        expect_at(m0 + 41, 2, 3'b111, 1'b1, 1'b0, 4'd2, "mask_drop_ignored");
        expect_at(m0 + 45, 2, 3'b111, 1'b1, 1'b0, 4'd2, "mask_hold");

        go_to(m0 + 50);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: expectation for edge %0d never checked", mon_e.name, mon_e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
